// File: rtl/player_lives_manager_pkg.sv
// Shared constants and types for the player lives bookkeeping and the lives display.
package player_lives_manager_pkg;

    localparam int PLAYER_LIVES_AMOUNT       = 5;
    localparam int PLAYER_LIVES_AMOUNT_WIDTH = $clog2(PLAYER_LIVES_AMOUNT + 1);

    localparam int DEFAULT_START_LIVES         = 3;
    localparam int DEFAULT_INVULN_FRAMES       = 120;
    localparam int DEFAULT_BLINK_PERIOD_FRAMES = 8;

    localparam logic [PLAYER_LIVES_AMOUNT_WIDTH-1:0] LIVES_MAX =
        PLAYER_LIVES_AMOUNT_WIDTH'(PLAYER_LIVES_AMOUNT);

    typedef enum logic [1:0] {
        PLAYING,
        INVULNERABLE,
        GAME_OVER
    } lives_state_t;

    // Add one life, clamped at the display's maximum.
    function automatic logic [PLAYER_LIVES_AMOUNT_WIDTH-1:0] lives_sat_inc(
        input logic [PLAYER_LIVES_AMOUNT_WIDTH-1:0] lives
    );
        if (lives >= LIVES_MAX) begin
            return LIVES_MAX;
        end
        return lives + 1'b1;
    endfunction

endpackage

// File: rtl/player_lives_manager_frame_countdown.sv
// Loadable down-counter advanced by frame ticks; o_done fires on the tick that
// takes it from 1 to 0 so the owner can change state on that same edge.
module frame_countdown
    import player_lives_manager_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_enable,
    input  logic         i_tick,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Count register: clear beats load, load beats tick; never wraps below zero.
    always_ff @(posedge clk) begin
        if (!resetN || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = i_enable && i_tick && (r_count == W'(1));

endmodule

// File: rtl/player_lives_manager.sv
// Player life count, post-hit invulnerability window and sprite blink.
// Optional feature macro: PLAYER_EXTRA_LIFE_EN (bonus lives via extra_life).
module player_lives_manager
    import player_lives_manager_pkg::*;
#(
    parameter int START_LIVES         = DEFAULT_START_LIVES,
    parameter int INVULN_FRAMES       = DEFAULT_INVULN_FRAMES,
    parameter int BLINK_PERIOD_FRAMES = DEFAULT_BLINK_PERIOD_FRAMES
) (
    input  logic                                 clk,
    input  logic                                 resetN,
    input  logic                                 startOfFrame,
    input  logic                                 player_hit,
    input  logic                                 extra_life,
    input  logic                                 new_game,
    output logic [PLAYER_LIVES_AMOUNT_WIDTH-1:0] remaining_lives,
    output logic                                 invulnerable,
    output logic                                 player_visible,
    output logic                                 life_lost,
    output logic                                 game_over
);

    localparam int CNT_W   = $clog2(INVULN_FRAMES + 1);
    localparam int BLINK_W = $clog2(BLINK_PERIOD_FRAMES + 1);
    localparam int LW      = PLAYER_LIVES_AMOUNT_WIDTH;

    localparam logic [LW-1:0]      LIVES_START = LW'(START_LIVES);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_PERIOD_FRAMES - 1);

    lives_state_t       r_state,     w_state_next;
    logic [LW-1:0]      r_lives,     w_lives_next;
    logic               r_visible,   w_visible_next;
    logic               r_life_lost, w_life_lost_next;
    logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_next;
    logic               w_load_window;
    logic               w_window_done;
    logic               w_extra;

`ifdef PLAYER_EXTRA_LIFE_EN
    assign w_extra = extra_life;
`else
    // Bonus lives are disabled in this build; the port is kept for a stable interface.
    logic w_extra_life_unused;
    assign w_extra_life_unused = extra_life;
    assign w_extra = 1'b0;
`endif

    frame_countdown #(
        .W (CNT_W)
    ) u_invuln_window (
        .clk          (clk),
        .resetN       (resetN),
        .i_clear      (new_game),
        .i_load       (w_load_window),
        .i_load_value (CNT_W'(INVULN_FRAMES)),
        .i_enable     (r_state == INVULNERABLE),
        .i_tick       (startOfFrame),
        .o_done       (w_window_done)
    );

    // Next-state logic: hit/bonus handling, window expiry and blink divider.
    always_comb begin
        w_state_next     = r_state;
        w_lives_next     = r_lives;
        w_visible_next   = r_visible;
        w_life_lost_next = 1'b0;
        w_blink_cnt_next = r_blink_cnt;
        w_load_window    = 1'b0;

        case (r_state)
            PLAYING: begin
                w_visible_next = 1'b1;
                if (player_hit) begin
                    if (w_extra || (r_lives > LW'(1))) begin
                        // A simultaneous bonus cancels the lost life but the hit still counts.
                        w_lives_next     = w_extra ? r_lives : (r_lives - 1'b1);
                        w_life_lost_next = 1'b1;
                        w_load_window    = 1'b1;
                        w_blink_cnt_next = '0;
                        w_visible_next   = 1'b0;
                        w_state_next     = INVULNERABLE;
                    end else begin
                        w_lives_next   = '0;
                        w_visible_next = 1'b0;
                        w_state_next   = GAME_OVER;
                    end
                end else if (w_extra) begin
                    w_lives_next = lives_sat_inc(r_lives);
                end
            end

            INVULNERABLE: begin
                if (w_extra) begin
                    w_lives_next = lives_sat_inc(r_lives);
                end
                if (startOfFrame) begin
                    if (w_window_done) begin
                        w_state_next     = PLAYING;
                        w_visible_next   = 1'b1;
                        w_blink_cnt_next = '0;
                    end else if (r_blink_cnt == BLINK_LAST) begin
                        w_blink_cnt_next = '0;
                        w_visible_next   = ~r_visible;
                    end else begin
                        w_blink_cnt_next = r_blink_cnt + 1'b1;
                    end
                end
            end

            GAME_OVER: begin
                w_visible_next = 1'b0;
            end

            default: begin
                w_state_next = PLAYING;
            end
        endcase
    end

    // State and output registers; new_game restarts bookkeeping exactly like reset.
    always_ff @(posedge clk) begin
        if (!resetN || new_game) begin
            r_state     <= PLAYING;
            r_lives     <= LIVES_START;
            r_visible   <= 1'b1;
            r_life_lost <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_lives     <= w_lives_next;
            r_visible   <= w_visible_next;
            r_life_lost <= w_life_lost_next;
            r_blink_cnt <= w_blink_cnt_next;
        end
    end

    assign remaining_lives = r_lives;
    assign invulnerable    = (r_state == INVULNERABLE);
    assign player_visible  = r_visible;
    assign life_lost       = r_life_lost;
    assign game_over       = (r_state == GAME_OVER);

endmodule

// File: tb/tb_player_lives_manager.sv
// Testbench for player_lives_manager: vector table, directed corner sequences and
// randomized traffic against a frame-level reference model.
// Honours PLAYER_EXTRA_LIFE_EN the same way the design does.
module tb_player_lives_manager;
    import player_lives_manager_pkg::*;

    localparam int START = 3;
    localparam int INV   = 120;
    localparam int BP    = 8;
    localparam int MAXL  = PLAYER_LIVES_AMOUNT;
`ifdef PLAYER_EXTRA_LIFE_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0;
    logic player_hit = 1'b0;
    logic extra_life = 1'b0;
    logic new_game = 1'b0;
    logic [PLAYER_LIVES_AMOUNT_WIDTH-1:0] remaining_lives;
    logic invulnerable, player_visible, life_lost, game_over;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 playing, 1 invulnerable, 2 game over.
    int m_lives = START;
    int m_mode = 0;
    int m_left = 0;
    int m_elapsed = 0;
    bit m_ll = 1'b0;

    player_lives_manager #(
        .START_LIVES         (START),
        .INVULN_FRAMES       (INV),
        .BLINK_PERIOD_FRAMES (BP)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .player_hit      (player_hit),
        .extra_life      (extra_life),
        .new_game        (new_game),
        .remaining_lives (remaining_lives),
        .invulnerable    (invulnerable),
        .player_visible  (player_visible),
        .life_lost       (life_lost),
        .game_over       (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rn, input bit ng, input bit sof, input bit hit, input bit xl);
        bit bonus;
        bonus = EXT && xl;
        m_ll = 1'b0;
        if (!rn || ng) begin
            m_lives = START; m_mode = 0; m_left = 0; m_elapsed = 0;
        end else if (m_mode == 0) begin
            if (hit && (bonus || m_lives > 1)) begin
                if (!bonus) m_lives = m_lives - 1;
                m_mode = 1; m_left = INV; m_elapsed = 0; m_ll = 1'b1;
            end else if (hit) begin
                m_lives = 0; m_mode = 2;
            end else if (bonus) begin
                m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
            end
        end else if (m_mode == 1) begin
            if (bonus) m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
            if (sof) begin
                m_left = m_left - 1;
                m_elapsed = m_elapsed + 1;
                if (m_left == 0) m_mode = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, step the model on the rising edge, compare just after.
    task automatic cyc(input bit rn, input bit ng, input bit sof, input bit hit, input bit xl);
        int exp_vis;
        @(negedge clk);
        resetN = rn; new_game = ng; startOfFrame = sof; player_hit = hit; extra_life = xl;
        @(posedge clk);
        model_step(rn, ng, sof, hit, xl);
        #1;
        exp_vis = (m_mode == 0) ? 1 : (m_mode == 2) ? 0 : (((m_elapsed / BP) % 2) == 1 ? 1 : 0);
        chk("m_lives", remaining_lives, m_lives);
        chk("m_invulnerable", invulnerable, (m_mode == 1) ? 1 : 0);
        chk("m_visible", player_visible, exp_vis);
        chk("m_life_lost", life_lost, m_ll);
        chk("m_game_over", game_over, (m_mode == 2) ? 1 : 0);
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            cyc(1, 0, 0, 0, 0);
            cyc(1, 0, 0, 0, 0);
            cyc(1, 0, 0, 0, 0);
            cyc(1, 0, 1, 0, 0);
        end
    endtask

    // Counts frames until invulnerable drops, bounded at 200 frames.
    task automatic measure_window(output int n);
        n = 0;
        for (int f = 0; f < 200; f++) begin
            if (!invulnerable) break;
            cyc(1, 0, 0, 0, 0);
            cyc(1, 0, 1, 0, 0);
            n++;
        end
    endtask

    typedef struct {
        bit rn, ng, sof, hit, xl;
        int lives;
        bit inv, vis, ll, go;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int sofs;
        int win;

        tbl[0]  = '{0, 0, 0, 0, 0, 3, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 0, 3, 0, 1, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, 0, 2, 1, 0, 1, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 2, 1, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 1, 0, 2, 1, 0, 0, 0};
        tbl[5]  = '{1, 0, 1, 0, 0, 2, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 3, 0, 1, 0, 0};
        tbl[7]  = '{1, 0, 0, 1, 0, 2, 1, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 3, 0, 1, 0, 0};
        tbl[9]  = '{1, 1, 0, 1, 0, 3, 0, 1, 0, 0};
        tbl[10] = '{1, 0, 0, 1, 0, 2, 1, 0, 1, 0};

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].rn, tbl[i].ng, tbl[i].sof, tbl[i].hit, tbl[i].xl);
            chk($sformatf("tbl%0d_lives", i), remaining_lives, tbl[i].lives);
            chk($sformatf("tbl%0d_inv", i), invulnerable, tbl[i].inv);
            chk($sformatf("tbl%0d_vis", i), player_visible, tbl[i].vis);
            chk($sformatf("tbl%0d_ll", i), life_lost, tbl[i].ll);
            chk($sformatf("tbl%0d_go", i), game_over, tbl[i].go);
        end

        // Reset and idle frames.
        cyc(0, 0, 0, 0, 0);
        frames(5);
        chk("idle_lives", remaining_lives, 3);
        chk("idle_inv", invulnerable, 0);
        chk("idle_vis", player_visible, 1);
        chk("idle_go", game_over, 0);

        // First hit, ignored second hit, window length and blink phases.
        cyc(1, 0, 0, 1, 0);
        chk("hit_lives", remaining_lives, 2);
        chk("hit_ll", life_lost, 1);
        chk("hit_inv", invulnerable, 1);
        chk("hit_vis", player_visible, 0);
        cyc(1, 0, 0, 0, 0);
        chk("hit_ll_one_cycle", life_lost, 0);
        sofs = 0;
        for (int f = 0; f < 200; f++) begin
            cyc(1, 0, 0, (f == 10), 0);
            if (f == 10) chk("second_hit_ignored", remaining_lives, 2);
            cyc(1, 0, 0, 0, 0);
            cyc(1, 0, 1, 0, 0);
            sofs++;
            if (sofs == BP - 1) chk("blink_hidden_phase", player_visible, 0);
            if (sofs == BP) chk("blink_first_toggle", player_visible, 1);
            if (sofs == 2 * BP) chk("blink_second_toggle", player_visible, 0);
            if (!invulnerable) break;
        end
        chk("invuln_window_len", sofs, INV);

        // Three spaced hits down to game over.
        cyc(1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 1, 0);
            chk($sformatf("hit%0d_lives", k), remaining_lives, 2 - k);
            chk($sformatf("hit%0d_ll", k), life_lost, (k < 2) ? 1 : 0);
            chk($sformatf("hit%0d_go", k), game_over, (k == 2) ? 1 : 0);
            frames(125);
        end
        chk("go_vis", player_visible, 0);
        cyc(1, 0, 0, 1, 0);
        chk("go_hit_lives", remaining_lives, 0);
        chk("go_hit_go", game_over, 1);

        // new_game out of game over, then during invulnerability.
        cyc(1, 1, 0, 0, 0);
        chk("ng_lives", remaining_lives, 3);
        chk("ng_go", game_over, 0);
        cyc(1, 0, 0, 1, 0);
        frames(50);
        cyc(1, 1, 0, 0, 0);
        chk("ng_mid_inv", invulnerable, 0);
        chk("ng_mid_lives", remaining_lives, 3);
        chk("ng_mid_vis", player_visible, 1);

`ifdef PLAYER_EXTRA_LIFE_EN
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("xl_to_max", remaining_lives, MAXL);
        cyc(1, 0, 0, 0, 1);
        chk("xl_saturate", remaining_lives, MAXL);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        frames(121);
        cyc(1, 0, 0, 1, 0);
        frames(121);
        chk("xl_at_one", remaining_lives, 1);
        cyc(1, 0, 0, 1, 1);
        chk("hitxl_lives", remaining_lives, 1);
        chk("hitxl_inv", invulnerable, 1);
        chk("hitxl_go", game_over, 0);
        chk("hitxl_ll", life_lost, 1);
`else
        cyc(1, 0, 0, 0, 1);
        chk("xl_ignored", remaining_lives, 3);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1);
        chk("xl_ignored_inv", remaining_lives, 2);
`endif

        // Reset mid-window, then a full-length window on the next hit.
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        frames(60);
        cyc(0, 0, 0, 0, 0);
        chk("rst_mid_inv", invulnerable, 0);
        chk("rst_mid_lives", remaining_lives, 3);
        chk("rst_mid_vis", player_visible, 1);
        chk("rst_mid_go", game_over, 0);
        cyc(1, 0, 0, 1, 0);
        measure_window(win);
        chk("rst_full_window", win, INV);

        // Randomized traffic against the model.
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 999) != 0),
                ($urandom_range(0, 599) == 0),
                ((i % 2) == 1),
                ($urandom_range(0, 99) < 3),
                ($urandom_range(0, 99) < 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_lives_manager.md
Name: player_lives_manager

Overview:
Owns the player's life count and post-hit invulnerability window. It consumes collision and bonus events and produces the `remaining_lives` bus that the lives-icon display reads. It also drives the player sprite blink enable and the game-over flag. It sits between the collision/game-control logic and the player/lives drawing blocks.

Parameters:
START_LIVES, 3, lives loaded on reset and on new_game; legal range 1..PLAYER_LIVES_AMOUNT.
INVULN_FRAMES, 120, frames of invulnerability after a non-fatal hit; legal range >=1.
BLINK_PERIOD_FRAMES, 8, frames per visible/hidden phase while invulnerable; legal range >=1.

Ports:
clk  input  1  system clock
resetN  input  1  synchronous active-low reset
startOfFrame  input  1  one-cycle pulse per video frame
player_hit  input  1  one-cycle pulse: collision between player and an enemy or enemy shot
extra_life  input  1  one-cycle pulse: bonus life awarded (used only with PLAYER_EXTRA_LIFE_EN)
new_game  input  1  one-cycle pulse: restart life bookkeeping
remaining_lives  output  PLAYER_LIVES_AMOUNT_WIDTH  current life count, 0..PLAYER_LIVES_AMOUNT
invulnerable  output  1  high while hits are ignored
player_visible  output  1  sprite draw enable (blink)
life_lost  output  1  one-cycle pulse on each non-fatal hit
game_over  output  1  level; high once lives reach 0

Behaviour:
- Reset values (resetN low at a clk edge):
  - remaining_lives=START_LIVES, state PLAYING, invulnerable=0, player_visible=1, life_lost=0, game_over=0.
  - Frame counter=0, blink phase=0.
- All outputs are registered and reflect an input event on the edge after it is sampled (1-cycle latency).
- Priority: resetN > new_game > player_hit/extra_life.
  - new_game in any state behaves exactly like reset.
  - new_game asserted mid-invulnerability cancels the window immediately.
- FSM state PLAYING:
  - player_hit with remaining_lives>1: lives-1; life_lost pulses 1 cycle; counter loads INVULN_FRAMES; blink phase clears; go to INVULNERABLE.
  - player_hit with remaining_lives==1: lives=0; go to GAME_OVER; life_lost stays 0.
- FSM state INVULNERABLE:
  - player_hit is ignored.
  - On each startOfFrame the counter decrements.
  - A startOfFrame that arrives with counter==1 sets counter=0 and returns to PLAYING on the same edge.
  - invulnerable=1 throughout.
- FSM state GAME_OVER:
  - game_over=1, player_visible=0, invulnerable=0.
  - player_hit and extra_life are ignored.
  - Only new_game or reset leaves this state.
- Blink:
  - In INVULNERABLE, a blink sub-counter counts startOfFrame pulses. Every BLINK_PERIOD_FRAMES frames it toggles player_visible.
  - The first phase after a hit is hidden: player_visible=0 on the cycle after the hit.
  - player_visible=1 in PLAYING.
- Counter width: $clog2(INVULN_FRAMES+1). Counter arithmetic never wraps below 0.
- remaining_lives never underflows below 0 and never exceeds PLAYER_LIVES_AMOUNT.

Optional Feature:
Macro: PLAYER_EXTRA_LIFE_EN.
- Defined:
  - extra_life in PLAYING or INVULNERABLE increments lives, saturating at PLAYER_LIVES_AMOUNT.
  - Simultaneous player_hit+extra_life in PLAYING: net lives unchanged, life_lost pulses, enter INVULNERABLE.
  - This also holds at lives==1: no game over; the player enters INVULNERABLE with 1 life.
- Undefined: the extra_life port exists but is ignored. Lives only decrease between new_game events.

Decomposition:
- Shared parameters package holds:
  - PLAYER_LIVES_AMOUNT and PLAYER_LIVES_AMOUNT_WIDTH (shared with the lives display).
  - The FSM state enum typedef lives_state_t {PLAYING, INVULNERABLE, GAME_OVER}.
  - Default INVULN_FRAMES and BLINK_PERIOD_FRAMES constants.
- One natural sub-module: frame_countdown.
  - Loadable down-counter advanced by startOfFrame, with a done pulse.
  - Reused for the invulnerability window.
  - The blink divider stays inline.

Test Plan:
1. Reset, then 5 idle frames -> remaining_lives=3, invulnerable=0, player_visible=1, game_over=0.
2. player_hit at lives=3 -> next cycle lives=2, life_lost=1 for exactly 1 cycle, invulnerable=1, player_visible=0. A second hit 10 frames later -> lives stays 2. invulnerable falls after exactly 120 startOfFrame pulses. player_visible toggles every 8 frames.
3. Three hits, each spaced >120 frames apart -> lives 2, 1, 0. On the third hit game_over=1, life_lost stays 0, player_visible=0. Further hits keep lives=0.
4. In GAME_OVER, new_game -> next cycle lives=3, PLAYING, game_over=0. new_game during invulnerability (frame 50) -> invulnerable=0 next cycle, lives=3.
5. (PLAYER_EXTRA_LIFE_EN) extra_life at lives=PLAYER_LIVES_AMOUNT -> unchanged. Hit+extra_life same cycle at lives=1 -> lives=1, invulnerable=1, game_over=0. Without the macro -> extra_life has no effect.
6. resetN low mid-invulnerability (frame 60) -> next edge restores all reset values. Counter restarts cleanly on the next hit (full 120 frames).
